// File: rtl/ddr_bank_pkg.sv
// -----------------------------------------------------------------------------
// ddr_bank_pkg
//   Shared types and helpers for the DDR frame-buffer bank scheduler.
//   BANK_W           : width of a bank id (bank id = DDR addr[24:23])
//   bank_t           : bank id type
//   state_t          : scheduler FSM states
//   lowest_free_bank : lowest bank id below num_banks not in the exclusion set
// -----------------------------------------------------------------------------
package ddr_bank_pkg;

   localparam int unsigned BANK_W    = 2;
   localparam int unsigned MAX_BANKS = 1 << BANK_W;

   typedef logic [BANK_W-1:0] bank_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_UPDATE,
      S_LOAD
   } state_t;

   // Scans from the top down so the last hit is the lowest legal id.
   function automatic bank_t lowest_free_bank(input bank_t       ex_a,
                                              input bank_t       ex_b,
                                              input bank_t       ex_c,
                                              input int unsigned num_banks);
      bank_t res;
      res = '0;
      for (int i = MAX_BANKS - 1; i >= 0; i--) begin
         if ((unsigned'(i) < num_banks) &&
             (bank_t'(i) != ex_a) && (bank_t'(i) != ex_b) && (bank_t'(i) != ex_c)) begin
            res = bank_t'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ddr_edge_det.sv
// -----------------------------------------------------------------------------
// ddr_edge_det
//   Registers a level input through two flops and flags its rising edge.
//   DDR_CLK : clock
//   DDR_RST : asynchronous reset, active low
//   sig_i   : level input
//   rise_o  : high for one cycle after sig_i is first seen high
// -----------------------------------------------------------------------------
module ddr_edge_det (
   input  logic DDR_CLK,
   input  logic DDR_RST,
   input  logic sig_i,
   output logic rise_o
);

   logic d0_q;
   logic d1_q;

   always_ff @(posedge DDR_CLK or negedge DDR_RST) begin
      if (!DDR_RST) begin
         d0_q <= 1'b0;
         d1_q <= 1'b0;
      end else begin
         d0_q <= sig_i;
         d1_q <= d0_q;
      end
   end

   assign rise_o = d0_q & ~d1_q;

endmodule

// File: rtl/ddr_bank_switch.sv
// -----------------------------------------------------------------------------
// ddr_bank_switch
//   Frame-buffer bank scheduler. Owns the camera write bank and the display
//   read bank, never lets them coincide, hands the newest complete frame to
//   the reader, and turns end-of-frame levels into one-cycle load pulses.
//
//   Parameters
//     NUM_BANKS   : banks in rotation (3..4)
//     WR_BANK_RST : wr_bank after reset
//     RD_BANK_RST : rd_bank after reset (differs from WR_BANK_RST, < NUM_BANKS)
//   Ports
//     DDR_CLK          in   clock
//     DDR_RST          in   asynchronous reset, active low
//     frame_wr_done    in   writer end-of-frame level, held until wr_load
//     frame_rd_done    in   reader end-of-frame level
//     wr_bank          out  bank the writer fills
//     wr_load          out  one-cycle pulse: writer reloads its address
//     rd_bank          out  bank the reader drains
//     rd_load          out  one-cycle pulse: reader reloads its address
//     first_frame_done out  sticky, set by the first completed write frame
//     frame_cnt, drop_cnt, repeat_cnt  out  16-bit saturating statistics
//
//   Build option
//     DDR_BANK_STATS_EN : when defined, adds the three statistics counters.
// -----------------------------------------------------------------------------
module ddr_bank_switch
   import ddr_bank_pkg::*;
#(
   parameter int unsigned NUM_BANKS   = 3,
   parameter bank_t       WR_BANK_RST = 2'd0,
   parameter bank_t       RD_BANK_RST = 2'd1
) (
   input  logic              DDR_CLK,
   input  logic              DDR_RST,
   input  logic              frame_wr_done,
   input  logic              frame_rd_done,
   output logic [BANK_W-1:0] wr_bank,
   output logic              wr_load,
   output logic [BANK_W-1:0] rd_bank,
   output logic              rd_load,
   output logic              first_frame_done
`ifdef DDR_BANK_STATS_EN
   ,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       repeat_cnt
`endif
);

   logic   wr_ev;
   logic   rd_ev;

   state_t state_q,       state_d;
   logic   wr_flag_q,     wr_flag_d;
   logic   rd_flag_q,     rd_flag_d;
   logic   wr_pend_q,     wr_pend_d;
   logic   rd_pend_q,     rd_pend_d;
   bank_t  wr_bank_q,     wr_bank_d;
   bank_t  rd_bank_q,     rd_bank_d;
   bank_t  ready_bank_q,  ready_bank_d;
   logic   ready_valid_q, ready_valid_d;
   logic   ffd_q,         ffd_d;
   logic   wr_load_q,     wr_load_d;
   logic   rd_load_q,     rd_load_d;

   // Bank selection for the current update, write part folded in first.
   logic   ready_valid_w;
   bank_t  ready_bank_w;
   logic   rd_swap;
   bank_t  rd_bank_nxt;
   bank_t  wr_bank_nxt;

   ddr_edge_det u_wr_edge (
      .DDR_CLK (DDR_CLK),
      .DDR_RST (DDR_RST),
      .sig_i   (frame_wr_done),
      .rise_o  (wr_ev)
   );

   ddr_edge_det u_rd_edge (
      .DDR_CLK (DDR_CLK),
      .DDR_RST (DDR_RST),
      .sig_i   (frame_rd_done),
      .rise_o  (rd_ev)
   );

   always_comb begin
      ready_valid_w = ready_valid_q;
      ready_bank_w  = ready_bank_q;
      if (wr_flag_q) begin
         ready_valid_w = 1'b1;
         ready_bank_w  = wr_bank_q;
      end
      rd_swap     = rd_flag_q && ready_valid_w && (ready_bank_w != rd_bank_q);
      rd_bank_nxt = rd_swap ? ready_bank_w : rd_bank_q;
      // The reader's previous bank is also skipped: on a simultaneous swap
      // the writer takes the remaining idle bank rather than the one the
      // display has only just released.
      wr_bank_nxt = lowest_free_bank(wr_bank_q, rd_bank_q, rd_bank_nxt, NUM_BANKS);
   end

   always_comb begin
      state_d       = state_q;
      wr_flag_d     = wr_flag_q;
      rd_flag_d     = rd_flag_q;
      wr_pend_d     = wr_pend_q;
      rd_pend_d     = rd_pend_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      ready_bank_d  = ready_bank_q;
      ready_valid_d = ready_valid_q;
      ffd_d         = ffd_q;
      wr_load_d     = 1'b0;
      rd_load_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (wr_ev || rd_ev || wr_pend_q || rd_pend_q) begin
               state_d   = S_UPDATE;
               wr_flag_d = wr_ev | wr_pend_q;
               rd_flag_d = rd_ev | rd_pend_q;
               wr_pend_d = 1'b0;
               rd_pend_d = 1'b0;
            end
         end
         S_UPDATE: begin
            state_d   = S_LOAD;
            wr_pend_d = wr_pend_q | wr_ev;
            rd_pend_d = rd_pend_q | rd_ev;
            if (wr_flag_q) begin
               wr_bank_d     = wr_bank_nxt;
               ready_bank_d  = wr_bank_q;
               ready_valid_d = 1'b1;
               ffd_d         = 1'b1;
            end
            if (rd_swap) begin
               rd_bank_d     = rd_bank_nxt;
               ready_valid_d = 1'b0;
            end
            // Registered so the pulse coincides with S_LOAD.
            wr_load_d = wr_flag_q;
            rd_load_d = rd_flag_q;
         end
         S_LOAD: begin
            state_d   = S_IDLE;
            wr_pend_d = wr_pend_q | wr_ev;
            rd_pend_d = rd_pend_q | rd_ev;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge DDR_CLK or negedge DDR_RST) begin
      if (!DDR_RST) begin
         state_q       <= S_IDLE;
         wr_flag_q     <= 1'b0;
         rd_flag_q     <= 1'b0;
         wr_pend_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         wr_bank_q     <= WR_BANK_RST;
         rd_bank_q     <= RD_BANK_RST;
         ready_bank_q  <= WR_BANK_RST;
         ready_valid_q <= 1'b0;
         ffd_q         <= 1'b0;
         wr_load_q     <= 1'b0;
         rd_load_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_flag_q     <= wr_flag_d;
         rd_flag_q     <= rd_flag_d;
         wr_pend_q     <= wr_pend_d;
         rd_pend_q     <= rd_pend_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         ready_bank_q  <= ready_bank_d;
         ready_valid_q <= ready_valid_d;
         ffd_q         <= ffd_d;
         wr_load_q     <= wr_load_d;
         rd_load_q     <= rd_load_d;
      end
   end

   assign wr_bank          = wr_bank_q;
   assign rd_bank          = rd_bank_q;
   assign wr_load          = wr_load_q;
   assign rd_load          = rd_load_q;
   assign first_frame_done = ffd_q;

`ifdef DDR_BANK_STATS_EN
   logic        upd_wr;
   logic        upd_rd;
   logic [15:0] frame_cnt_q;
   logic [15:0] drop_cnt_q;
   logic [15:0] repeat_cnt_q;

   assign upd_wr = (state_q == S_UPDATE) && wr_flag_q;
   assign upd_rd = (state_q == S_UPDATE) && rd_flag_q;

   always_ff @(posedge DDR_CLK or negedge DDR_RST) begin
      if (!DDR_RST) begin
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
         repeat_cnt_q <= '0;
      end else begin
         if (upd_wr && (frame_cnt_q != '1)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         // An unread ready frame is being replaced.
         if (upd_wr && ready_valid_q && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
         if (upd_rd && !rd_swap && (repeat_cnt_q != '1)) begin
            repeat_cnt_q <= repeat_cnt_q + 16'd1;
         end
      end
   end

   assign frame_cnt  = frame_cnt_q;
   assign drop_cnt   = drop_cnt_q;
   assign repeat_cnt = repeat_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_bank_switch.sv
// -----------------------------------------------------------------------------
// tb_ddr_bank_switch
//   Self-checking bench for ddr_bank_switch (default parameters, 3 banks).
//   Expected load events are queued when stimulus is driven and compared
//   when a load pulse appears; extra sequences cover pending events and
//   reset during an update.
// -----------------------------------------------------------------------------
module tb_ddr_bank_switch;

   typedef struct {
      int wr;   // drive frame_wr_done
      int rd;   // drive frame_rd_done
      int cyc;  // cycle the load pulse must appear
      int wb;
      int rb;
      int wl;
      int rl;
      int ffd;
      int fc;   // cumulative statistics since last reset
      int dc;
      int rc;
   } vec_t;

   logic       clk = 1'b0;
   logic       DDR_RST;
   logic       frame_wr_done;
   logic       frame_rd_done;
   logic [1:0] wr_bank;
   logic       wr_load;
   logic [1:0] rd_bank;
   logic       rd_load;
   logic       first_frame_done;
`ifdef DDR_BANK_STATS_EN
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;
   logic [15:0] repeat_cnt;
`endif

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   vec_t sb [$];
   vec_t mon_e;
   vec_t vecs [9];

   ddr_bank_switch dut (
      .DDR_CLK          (clk),
      .DDR_RST          (DDR_RST),
      .frame_wr_done    (frame_wr_done),
      .frame_rd_done    (frame_rd_done),
      .wr_bank          (wr_bank),
      .wr_load          (wr_load),
      .rd_bank          (rd_bank),
      .rd_load          (rd_load),
      .first_frame_done (first_frame_done)
`ifdef DDR_BANK_STATS_EN
      ,
      .frame_cnt        (frame_cnt),
      .drop_cnt         (drop_cnt),
      .repeat_cnt       (repeat_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Scoreboard: every load pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (DDR_RST) begin
         if (wr_load || rd_load) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_load: got wr_load=%0d rd_load=%0d, required none (cycle %0d)",
                        wr_load, rd_load, cyc);
            end else begin
               mon_e = sb.pop_front();
               check("load_cycle", cyc, mon_e.cyc);
               check("wr_load", int'(wr_load), mon_e.wl);
               check("rd_load", int'(rd_load), mon_e.rl);
               check("wr_bank", int'(wr_bank), mon_e.wb);
               check("rd_bank", int'(rd_bank), mon_e.rb);
               check("first_frame_done", int'(first_frame_done), mon_e.ffd);
`ifdef DDR_BANK_STATS_EN
               check("frame_cnt", int'(frame_cnt), mon_e.fc);
               check("drop_cnt", int'(drop_cnt), mon_e.dc);
               check("repeat_cnt", int'(repeat_cnt), mon_e.rc);
`endif
            end
         end
         check("bank_distinct", int'(wr_bank != rd_bank), 1);
      end
   end

   task automatic push_exp(input vec_t v, input int lat);
      vec_t s;
      s     = v;
      s.cyc = cyc + lat;
      sb.push_back(s);
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0) && (n < 20)) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d loads missing, required 0", name, sb.size());
         sb.delete();
      end
      #1;
   endtask

   task automatic apply(input vec_t v, input string name);
      @(posedge clk);
      #1;
      frame_wr_done = (v.wr != 0);
      frame_rd_done = (v.rd != 0);
      push_exp(v, 3);
      wait_empty(name);
      repeat (2) @(posedge clk);
      #1;
      frame_wr_done = 1'b0;
      frame_rd_done = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //         wr rd cyc wb rb wl rl ffd fc dc rc
      vecs[0] = '{1, 0, 0, 2, 1, 1, 0, 1, 1, 0, 0};  // first frame, writer skips 0 and 1
      vecs[1] = '{0, 1, 0, 2, 0, 0, 1, 1, 1, 0, 0};  // reader takes frame in bank 0
      vecs[2] = '{1, 1, 0, 1, 2, 1, 1, 1, 2, 0, 0};  // simultaneous: reader gets 2, writer 1
      vecs[3] = '{1, 0, 0, 0, 2, 1, 0, 1, 3, 0, 0};
      vecs[4] = '{1, 0, 0, 1, 2, 1, 0, 1, 4, 1, 0};  // overwrites unread frame
      vecs[5] = '{1, 0, 0, 0, 2, 1, 0, 1, 5, 2, 0};  // overwrites unread frame
      vecs[6] = '{0, 1, 0, 0, 1, 0, 1, 1, 5, 2, 0};  // newest frame (bank 1)
      vecs[7] = '{0, 1, 0, 0, 1, 0, 1, 1, 5, 2, 1};  // nothing new: repeat
      vecs[8] = '{1, 1, 0, 2, 0, 1, 1, 1, 6, 2, 1};

      DDR_RST       = 1'b0;
      frame_wr_done = 1'b0;
      frame_rd_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) DDR_RST = 1'b1;

      // Idle after reset: no pulses, reset banks.
      repeat (20) @(posedge clk);
      #1;
      check("rst_wr_bank", int'(wr_bank), 0);
      check("rst_rd_bank", int'(rd_bank), 1);
      check("rst_first_frame_done", int'(first_frame_done), 0);
      check("rst_wr_load", int'(wr_load), 0);
      check("rst_rd_load", int'(rd_load), 0);

      for (int i = 0; i < 9; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Read event lands while the write swap is in S_LOAD: held pending.
      @(posedge clk);
      #1;
      frame_wr_done = 1'b1;
      v = '{1, 0, 0, 1, 0, 1, 0, 1, 7, 2, 1};
      push_exp(v, 3);
      repeat (2) @(posedge clk);
      #1;
      frame_rd_done = 1'b1;
      v = '{0, 1, 0, 1, 2, 0, 1, 1, 7, 2, 1};
      push_exp(v, 4);
      wait_empty("pending");
      frame_wr_done = 1'b0;
      frame_rd_done = 1'b0;
      repeat (3) @(posedge clk);

      // Reset while in S_UPDATE: swap aborted, no pulse afterwards.
      @(posedge clk);
      #1;
      frame_wr_done = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      DDR_RST       = 1'b0;
      frame_wr_done = 1'b0;
      #1;
      check("midrst_wr_bank", int'(wr_bank), 0);
      check("midrst_rd_bank", int'(rd_bank), 1);
      check("midrst_first_frame_done", int'(first_frame_done), 0);
      check("midrst_wr_load", int'(wr_load), 0);
      check("midrst_rd_load", int'(rd_load), 0);
`ifdef DDR_BANK_STATS_EN
      check("midrst_frame_cnt", int'(frame_cnt), 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk) DDR_RST = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_wr_bank", int'(wr_bank), 0);
      check("post_rst_rd_bank", int'(rd_bank), 1);

      // Read before any frame is written: pulse only, bank unchanged.
      v = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1};
      apply(v, "rd_before_first");

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
